// File: rtl/z80_bus_responder_if.sv
// Sound-CPU bus bundle: Z80 strobes/data, the ROM request/acknowledge port and
// the sound-latch input, as seen from the CPU/arbiter side (master) and the responder (slave).
interface z80_bus_responder_if #(
  parameter int ROM_AW = 15
);
  logic [15:0]       Z80_ADDR;
  logic [7:0]        Z80_DOUT;
  logic              nMREQ, nIORQ, nRD, nWR, nRFSH;
  logic [7:0]        Z80_DIN;
  logic              nWAIT;
  logic              nINT;
  logic              ROM_REQ;
  logic [ROM_AW-1:0] ROM_ADDR;
  logic [7:0]        ROM_DATA;
  logic              ROM_ACK;
  logic [7:0]        LATCH_DATA;
  logic              LATCH_WR;

  modport slave (
    input  Z80_ADDR, Z80_DOUT, nMREQ, nIORQ, nRD, nWR, nRFSH,
    input  ROM_DATA, ROM_ACK, LATCH_DATA, LATCH_WR,
    output Z80_DIN, nWAIT, nINT, ROM_REQ, ROM_ADDR
  );

  modport master (
    output Z80_ADDR, Z80_DOUT, nMREQ, nIORQ, nRD, nWR, nRFSH,
    output ROM_DATA, ROM_ACK, LATCH_DATA, LATCH_WR,
    input  Z80_DIN, nWAIT, nINT, ROM_REQ, ROM_ADDR
  );
endinterface

// File: rtl/z80_bus_responder.sv
// Sound Z80 bus target: ROM via request/ack with wait states, 2 KB work RAM,
// sound latch at 0xA000 with latch-driven interrupt.
module z80_bus_responder #(
  parameter int ROM_AW = 15,
  parameter int RAM_AW = 11
) (
  input  logic               clk,
  input  logic               RESET,
  z80_bus_responder_if.slave bus
);
  localparam logic [15:0] RAM_BASE  = 16'h8000;
  localparam logic [15:0] LATCH_ADR = 16'hA000;

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t            state, state_nxt;
  logic              req_set, req_clr, capture;
  logic              rom_req;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_q;
  logic [7:0]        latch;
  logic              nint;
  logic              wr_prev, latch_rd_prev;
  logic [7:0]        ram [0:(2**RAM_AW)-1];
  logic [7:0]        ram_q;

  logic mem_cyc, rom_sel, ram_sel, latch_sel, rom_rd, latch_rd, wr_act, ram_we;

  assign mem_cyc   = ~bus.nMREQ & bus.nRFSH;
  assign rom_sel   = ~bus.Z80_ADDR[15];
  assign ram_sel   = bus.Z80_ADDR[15:RAM_AW] == RAM_BASE[15:RAM_AW];
  assign latch_sel = bus.Z80_ADDR == LATCH_ADR;
  assign rom_rd    = mem_cyc & ~bus.nRD & rom_sel;
  assign latch_rd  = mem_cyc & ~bus.nRD & latch_sel;
  assign wr_act    = mem_cyc & ~bus.nWR;
  // one write per bus cycle: only the first clk of a held nWR counts
  assign ram_we    = wr_act & ~wr_prev & ram_sel;

  always_comb begin
    state_nxt = state;
    req_set   = 1'b0;
    req_clr   = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: if (rom_rd) begin
        state_nxt = REQ;
        req_set   = 1'b1;
      end
      REQ: if (bus.nMREQ) begin
        // aborted cycle: drop the request, a late ACK lands in IDLE and is ignored
        state_nxt = IDLE;
        req_clr   = 1'b1;
      end else if (bus.ROM_ACK) begin
        state_nxt = DONE;
        req_clr   = 1'b1;
        capture   = 1'b1;
      end
      DONE: if (bus.nMREQ) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state         <= IDLE;
      rom_req       <= 1'b0;
      rom_addr      <= '0;
      rom_q         <= 8'h00;
      latch         <= 8'h00;
      nint          <= 1'b1;
      wr_prev       <= 1'b0;
      latch_rd_prev <= 1'b0;
    end else begin
      state         <= state_nxt;
      wr_prev       <= wr_act;
      latch_rd_prev <= latch_rd;
      if (req_set) begin
        rom_req  <= 1'b1;
        rom_addr <= bus.Z80_ADDR[ROM_AW-1:0];
      end else if (req_clr) begin
        rom_req  <= 1'b0;
      end
      if (capture) rom_q <= bus.ROM_DATA;
      // a new code in the same cycle as the acknowledging read keeps the interrupt pending
      if (bus.LATCH_WR) begin
        latch <= bus.LATCH_DATA;
        nint  <= 1'b0;
      end else if (latch_rd && !latch_rd_prev) begin
        nint  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) ram[bus.Z80_ADDR[RAM_AW-1:0]] <= bus.Z80_DOUT;
    ram_q <= ram[bus.Z80_ADDR[RAM_AW-1:0]];
  end

  always_comb begin
    bus.Z80_DIN = 8'hFF;
    if (bus.nIORQ) begin
      if (rom_sel)        bus.Z80_DIN = rom_q;
      else if (ram_sel)   bus.Z80_DIN = ram_q;
      else if (latch_sel) bus.Z80_DIN = latch;
    end
  end

  assign bus.nWAIT    = RESET | ~(rom_rd & (state != DONE));
  assign bus.nINT     = nint;
  assign bus.ROM_REQ  = rom_req;
  assign bus.ROM_ADDR = rom_addr;
endmodule

// File: tb/tb_z80_bus_responder.sv
// Bench for z80_bus_responder: directed + random bus cycles, expected read data
// queued by the drivers and popped/compared by an independent monitor.
module tb_z80_bus_responder;
  logic clk;
  logic RESET;
  int   checks;
  int   failures;
  logic rd_strobe;

  z80_bus_responder_if #(.ROM_AW(15)) bus ();

  z80_bus_responder #(.ROM_AW(15), .RAM_AW(11)) dut (
    .clk   (clk),
    .RESET (RESET),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  logic [7:0]  m_ram [0:2047];
  logic [15:0] m_written[$];
  logic [7:0]  m_romq;
  logic [7:0]  m_latch;
  logic        m_pend;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // monitor: whenever the driver marks read data as due, compare against the queue head
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rd_strobe) begin
        if (exp_q.size() == 0) chk("scoreboard_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          if (bus.Z80_DIN !== e.data)
            $display("  read at addr 0x%04h", e.addr);
          chk("rd_data", 32'(bus.Z80_DIN), 32'(e.data));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  function automatic logic is_ram(input logic [15:0] a);
    return (a >= 16'h8000) && (a <= 16'h87FF);
  endfunction

  function automatic logic [7:0] model_read(input logic [15:0] a);
    if (!a[15])           return m_romq;
    else if (is_ram(a))   return m_ram[a[10:0]];
    else if (a == 16'hA000) return m_latch;
    else                  return 8'hFF;
  endfunction

  task automatic push_exp(input logic [15:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic release_bus();
    bus.nMREQ = 1'b1; bus.nIORQ = 1'b1; bus.nRD = 1'b1; bus.nWR = 1'b1; bus.nRFSH = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    RESET = 1'b1;
    release_bus();
    repeat (3) @(posedge clk);
    #1 RESET = 1'b0;
    m_romq = 8'h00; m_latch = 8'h00; m_pend = 1'b0;
  endtask

  // ROM read with ACK k cycles after the read first appears (c0); k wait cycles follow c0
  task automatic rom_read(input logic [15:0] a, input int k, input logic [7:0] d);
    int low;
    @(posedge clk); #1;
    bus.Z80_ADDR = a; bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    @(negedge clk);
    chk("rom_wait_c0", 32'(bus.nWAIT), 32'd0);
    low = 0;
    for (int i = 1; i <= k; i++) begin
      @(posedge clk); #1;
      if (i == k) begin bus.ROM_ACK = 1'b1; bus.ROM_DATA = d; end
      @(negedge clk);
      if (i == 1) begin
        chk("rom_req_set", 32'(bus.ROM_REQ), 32'd1);
        chk("rom_addr", 32'(bus.ROM_ADDR), 32'(a[14:0]));
      end
      if (!bus.nWAIT) low++;
    end
    @(posedge clk); #1;
    bus.ROM_ACK = 1'b0; bus.ROM_DATA = 8'($urandom);
    m_romq = d;
    push_exp(a, model_read(a));
    rd_strobe = 1'b1;
    @(negedge clk);
    chk("rom_wait_count", 32'(low), 32'(k));
    chk("rom_wait_release", 32'(bus.nWAIT), 32'd1);
    chk("rom_req_clear", 32'(bus.ROM_REQ), 32'd0);
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    release_bus();
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    bus.Z80_ADDR = a; bus.Z80_DOUT = d; bus.nMREQ = 1'b0; bus.nWR = 1'b0;
    @(negedge clk);
    chk("wr_nwait", 32'(bus.nWAIT), 32'd1);
    // second clk of the same cycle with changed data must not write again
    @(posedge clk); #1;
    bus.Z80_DOUT = ~d;
    @(negedge clk);
    chk("wr_no_romreq", 32'(bus.ROM_REQ), 32'd0);
    @(posedge clk); #1;
    release_bus();
    if (is_ram(a)) begin
      m_ram[a[10:0]] = d;
      m_written.push_back(a);
    end
  endtask

  task automatic mem_read(input logic [15:0] a);
    @(posedge clk); #1;
    bus.Z80_ADDR = a; bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    @(negedge clk);
    chk("rd_nwait", 32'(bus.nWAIT), 32'd1);
    @(posedge clk); #1;
    push_exp(a, model_read(a));
    rd_strobe = 1'b1;
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    release_bus();
  endtask

  task automatic io_read(input logic [15:0] a);
    @(posedge clk); #1;
    bus.Z80_ADDR = a; bus.nIORQ = 1'b0; bus.nRD = 1'b0;
    push_exp(a, 8'hFF);
    rd_strobe = 1'b1;
    @(negedge clk);
    chk("io_nwait", 32'(bus.nWAIT), 32'd1);
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    release_bus();
  endtask

  task automatic latch_wr(input logic [7:0] d);
    @(posedge clk); #1;
    bus.LATCH_WR = 1'b1; bus.LATCH_DATA = d;
    @(posedge clk); #1;
    bus.LATCH_WR = 1'b0;
    m_latch = d; m_pend = 1'b1;
    @(negedge clk);
    chk("latch_nint_set", 32'(bus.nINT), 32'd0);
  endtask

  task automatic latch_read(input logic same, input logic [7:0] d);
    @(posedge clk); #1;
    bus.Z80_ADDR = 16'hA000; bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    if (same) begin bus.LATCH_WR = 1'b1; bus.LATCH_DATA = d; end
    @(negedge clk);
    chk("latch_rd_nwait", 32'(bus.nWAIT), 32'd1);
    @(posedge clk); #1;
    bus.LATCH_WR = 1'b0;
    if (same) begin m_latch = d; m_pend = 1'b1; end
    else m_pend = 1'b0;
    push_exp(16'hA000, m_latch);
    rd_strobe = 1'b1;
    @(negedge clk);
    chk("latch_rd_nint", 32'(bus.nINT), 32'(!m_pend));
    @(posedge clk); #1;
    rd_strobe = 1'b0;
    @(negedge clk);
    chk("latch_rd_nint_hold", 32'(bus.nINT), 32'(!m_pend));
    @(posedge clk); #1;
    release_bus();
  endtask

  function automatic logic [15:0] rand_ram_addr();
    if ($urandom_range(0, 1) == 0) return 16'h8000 + 16'($urandom_range(0, 31));
    else                           return 16'h8000 + 16'($urandom_range(2016, 2047));
  endfunction

  function automatic logic [15:0] rand_open_addr();
    logic [15:0] a;
    a = 16'h8800 + 16'($urandom_range(0, 16'h77FF));
    if (a == 16'hA000) a = 16'hA001;
    return a;
  endfunction

  initial begin
    checks = 0; failures = 0; rd_strobe = 1'b0;
    RESET = 1'b1;
    bus.Z80_ADDR = 16'h0000; bus.Z80_DOUT = 8'h00;
    release_bus();
    bus.ROM_DATA = 8'h00; bus.ROM_ACK = 1'b0;
    bus.LATCH_DATA = 8'h00; bus.LATCH_WR = 1'b0;
    m_romq = 8'h00; m_latch = 8'h00; m_pend = 1'b0;

    do_reset();
    @(posedge clk); #1 bus.Z80_ADDR = 16'h9000;
    @(negedge clk);
    chk("idle_nwait", 32'(bus.nWAIT), 32'd1);
    chk("idle_nint", 32'(bus.nINT), 32'd1);
    chk("idle_romreq", 32'(bus.ROM_REQ), 32'd0);
    chk("idle_din_open", 32'(bus.Z80_DIN), 32'hFF);
    bus.Z80_ADDR = 16'h0000;
    @(negedge clk);
    chk("reset_romq", 32'(bus.Z80_DIN), 32'h00);

    rom_read(16'h1234, 3, 8'h5A);
    rom_read(16'h1235, 1, 8'hA5);          // back-to-back: fresh request
    mem_write(16'h8010, 8'hC3);
    mem_read(16'h8010);
    mem_write(16'h87FF, 8'h3C);
    mem_read(16'h87FF);
    mem_read(16'h8800);
    mem_write(16'h0100, 8'h99);
    io_read(16'h0042);

    latch_wr(8'h21);
    latch_read(1'b0, 8'h00);
    latch_read(1'b1, 8'h44);
    latch_read(1'b0, 8'h00);

    // refresh cycle in ROM space must not start a fetch
    @(posedge clk); #1;
    bus.Z80_ADDR = 16'h0055; bus.nMREQ = 1'b0; bus.nRFSH = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rfsh_nwait", 32'(bus.nWAIT), 32'd1);
      chk("rfsh_romreq", 32'(bus.ROM_REQ), 32'd0);
    end
    @(posedge clk); #1 release_bus();

    // reset while a request is outstanding, then a late ACK
    do_reset();
    @(posedge clk); #1;
    bus.Z80_ADDR = 16'h0200; bus.nMREQ = 1'b0; bus.nRD = 1'b0;
    @(posedge clk); #1 RESET = 1'b1;
    @(negedge clk);
    chk("rst_req_pending", 32'(bus.ROM_REQ), 32'd1);
    chk("rst_nwait_forced", 32'(bus.nWAIT), 32'd1);
    @(posedge clk); #1;
    RESET = 1'b0; release_bus();
    bus.ROM_ACK = 1'b1; bus.ROM_DATA = 8'h77;
    m_romq = 8'h00; m_latch = 8'h00; m_pend = 1'b0;
    @(negedge clk);
    chk("rst_req_drop", 32'(bus.ROM_REQ), 32'd0);
    @(posedge clk); #1;
    bus.ROM_ACK = 1'b0; bus.Z80_ADDR = 16'h0000;
    @(negedge clk);
    chk("rst_ack_ignored_req", 32'(bus.ROM_REQ), 32'd0);
    chk("rst_romq_kept", 32'(bus.Z80_DIN), 32'h00);
    rom_read(16'h0300, 2, 8'h6E);

    for (int n = 0; n < 250; n++) begin
      case ($urandom_range(0, 8))
        0, 1: rom_read(16'($urandom_range(0, 16'h7FFF)), $urandom_range(1, 4), 8'($urandom));
        2:    mem_write(rand_ram_addr(), 8'($urandom));
        3:    if (m_written.size() > 0) mem_read(m_written[$urandom_range(0, m_written.size() - 1)]);
              else mem_write(rand_ram_addr(), 8'($urandom));
        4:    if ($urandom_range(0, 1) == 0) mem_read(rand_open_addr());
              else mem_write(rand_open_addr(), 8'($urandom));
        5:    latch_wr(8'($urandom));
        6:    latch_read(1'($urandom_range(0, 1)), 8'($urandom));
        7:    io_read(16'($urandom));
        default: mem_write(16'($urandom_range(0, 16'h7FFF)), 8'($urandom));
      endcase
      @(negedge clk);
      chk("nint_model", 32'(bus.nINT), 32'(!m_pend));
    end

    repeat (3) @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
